// File: rtl/lms_reader_pkg.sv
// Shared definitions for the LMS FIFO frame reader.
// Holds the reader FSM state type and the default sample width, frame
// length and underrun timeout used as parameter defaults.
package lms_reader_pkg;

  localparam int unsigned LMS_SAMPLE_W         = 16;
  localparam int unsigned LMS_FRAME_LEN        = 256;
  localparam int unsigned LMS_UNDERRUN_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/lms_out_reg_stage.sv
// Single-entry registered valid/ready output stage with first/last sideband.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              drops any held sample (m_valid cleared)
//   load               capture in_data/in_first/in_last into the register
//   in_data/first/last sample and frame markers to capture
//   m_ready            downstream accept
//   m_valid/m_data/m_first/m_last  registered output stream
// Load wins over a simultaneous accept so the stage sustains 1 sample/cycle.
module lms_out_reg_stage
  import lms_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LMS_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_first <= in_first;
      m_last  <= in_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lms_fifo_frame_reader.sv
// Read-side consumer of the LMS sample prefetch FIFO. A start pulse pops
// exactly FRAME_LEN samples and forwards them on a registered valid/ready
// stream tagged with first/last markers. FIFO starvation for TIMEOUT
// consecutive cycles ends the frame early and sets a sticky underrun flag.
// Ports:
//   rd_clk, rd_rst     clock, synchronous active-high reset
//   start, abort       frame start pulse (IDLE only), synchronous cancel
//   rd_vld, rd_data    FIFO head (prefetch), rd_en pop strobe
//   m_valid/m_ready/m_data/m_first/m_last  output stream to the LMS core
//   busy               not IDLE
//   frame_done         one-cycle pulse after a complete frame is handed off
//   underrun           sticky; cleared by reset or the next accepted start
// Optional: define LMS_FRAME_READER_STATS_EN to add saturating frame_cnt and
// underrun_cnt outputs.
module lms_fifo_frame_reader
  import lms_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LMS_SAMPLE_W,
  parameter int unsigned FRAME_LEN  = LMS_FRAME_LEN,
  parameter int unsigned TIMEOUT    = LMS_UNDERRUN_TIMEOUT
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
`ifdef LMS_FRAME_READER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDLE_W-1:0] TMO_C  = IDLE_W'(TIMEOUT - 1);

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              underrun_q, underrun_d;
  logic              done_q, done_d;
  logic              pop;
  logic              und_set;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    und_set    = 1'b0;
    // Abort outranks everything, including a start seen in IDLE; the FETCH
    // branch is skipped so no pop can happen on the abort cycle.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = FETCH;
            cnt_d      = '0;
            idle_d     = '0;
            underrun_d = 1'b0;
          end
        end
        FETCH: begin
          pop = rd_vld && (!m_valid || m_ready) && (cnt_q < LEN_C);
          if (pop) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_C) state_d = DRAIN;
          end
          if (rd_vld) begin
            idle_d = '0;
          end else if (idle_q == TMO_C) begin
            underrun_d = 1'b1;
            und_set    = 1'b1;
            state_d    = DRAIN;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!m_valid || m_ready) begin
            state_d = IDLE;
            done_d  = (cnt_q == LEN_C) && !underrun_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idle_q     <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  // Never pop while reset is asserted: the sample would be lost.
  assign rd_en      = pop && !rd_rst;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign underrun   = underrun_q;

  lms_out_reg_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .flush   (abort),
    .load    (rd_en),
    .in_data (rd_data),
    .in_first(cnt_q == '0),
    .in_last (cnt_q == LAST_C),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_first (m_first),
    .m_last  (m_last)
  );

`ifdef LMS_FRAME_READER_STATS_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      if (done_d && !rd_rst && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      if (und_set && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lms_fifo_frame_reader.sv
module tb_lms_fifo_frame_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst, start, abort, rd_vld, rd_en;
  logic [DW-1:0] rd_data, m_data;
  logic          m_valid, m_ready, m_first, m_last, busy, frame_done, underrun;
`ifdef LMS_FRAME_READER_STATS_EN
  logic [15:0]   frame_cnt, underrun_cnt;
`endif

  always #5 rd_clk = ~rd_clk;

  lms_fifo_frame_reader #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .TIMEOUT   (TO)
  ) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .start     (start),
    .abort     (abort),
    .rd_vld    (rd_vld),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_first   (m_first),
    .m_last    (m_last),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
`ifdef LMS_FRAME_READER_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt)
`endif
  );

  // Prefetch FIFO model: head entry visible whenever non-empty.
  logic [DW-1:0] fifo_mem [0:31];
  logic [5:0]    head = '0;
  logic [5:0]    tail = '0;
  logic          fifo_clr = 1'b0;

  assign rd_vld  = (head != tail);
  assign rd_data = fifo_mem[head[4:0]];

  always @(posedge rd_clk) begin
    if (fifo_clr) head <= tail;
    else if (rd_en) head <= head + 6'd1;
  end

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int fd_cnt = 0;
  int last_seen = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  logic          prev_stall = 1'b0;
  logic          prev_skip = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge rd_clk) begin
    exp_t e;
    if (rd_en) pop_cnt++;
    if (frame_done) fd_cnt++;
    if (m_valid && m_last) last_seen++;
    if (m_valid && !m_ready) check("stall_rd_en", {31'd0, rd_en}, 32'd0);
    if (prev_stall && !prev_skip) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got data %0h expected none", m_data);
      end else begin
        e = sb.pop_front();
        check("out_data", {16'd0, m_data}, {16'd0, e.d});
        check("out_first", {31'd0, m_first}, {31'd0, e.f});
        check("out_last", {31'd0, m_last}, {31'd0, e.l});
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_skip  = abort || rd_rst;
  end

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[tail[4:0]] = d;
    tail = tail + 6'd1;
  endtask

  task automatic expect_s(input logic [DW-1:0] d, input logic f, input logic l);
    exp_t e;
    e.d = d;
    e.f = f;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic load_frame(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push(base + DW'(i));
      expect_s(base + DW'(i), (i == 0), (i == FL - 1));
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 80) begin
      tick;
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic flush_fifo;
    fifo_clr = 1'b1;
    tick;
    fifo_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
    check({tag, "_m_first"}, {31'd0, m_first}, 32'd0);
    check({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, l0, fi, li, ui, n;
    logic [19:0] rv, mv, fd, bs;
    logic [3:0]  pat;

    rd_rst  = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick;
    @(negedge rd_clk);
    check_reset_outputs("reset");
    tick;
    rd_rst = 1'b0;
    tick;

    // Full frame, continuous.
    f0 = fd_cnt;
    load_frame(16'h0001, FL);
    pulse_start;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      rv[i] = rd_en;
      mv[i] = m_valid;
      fd[i] = frame_done;
      bs[i] = busy;
    end
    fi = -1;
    for (int i = 19; i >= 0; i--) if (rv[i]) fi = i;
    check("t1_first_pop_cycle", fi, 0);
    if (fi < 0 || fi > 14) fi = 0;
    check("t1_valid_run", {28'd0, mv[fi+1], mv[fi+2], mv[fi+3], mv[fi+4]}, 32'hF);
    check("t1_valid_end", {31'd0, mv[fi+5]}, 32'd0);
    check("t1_done_pulse", {30'd0, fd[fi+4], fd[fi+5]}, 32'd1);
    check("t1_busy_fall", {30'd0, bs[fi+4], bs[fi+5]}, 32'd2);
    tick;
    check("t1_done_count", fd_cnt - f0, 1);

    // Backpressure with m_ready pattern 1,0,0,1.
    p0  = pop_cnt;
    f0  = fd_cnt;
    pat = 4'b1001;
    load_frame(16'h0011, FL);
    pulse_start;
    for (int k = 0; k < 80 && busy; k++) begin
      m_ready = pat[k % 4];
      tick;
    end
    m_ready = 1'b1;
    check("t2_idle", {31'd0, busy}, 32'd0);
    tick;
    check("t2_pops", pop_cnt - p0, 4);
    check("t2_done_count", fd_cnt - f0, 1);
    check("t2_sb_empty", sb.size(), 0);

    // Underrun: only two samples available.
    p0 = pop_cnt;
    f0 = fd_cnt;
    l0 = last_seen;
    push(16'h0021);
    push(16'h0022);
    expect_s(16'h0021, 1'b1, 1'b0);
    expect_s(16'h0022, 1'b0, 1'b0);
    pulse_start;
    li = -100;
    ui = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge rd_clk);
      if (rd_en) li = i;
      if (underrun && ui < 0) ui = i;
    end
    check("t3_underrun_delay", ui - li, 9);
    tick;
    wait_idle("t3_idle_timeout");
    check("t3_underrun_flag", {31'd0, underrun}, 32'd1);
    check("t3_no_done", fd_cnt - f0, 0);
    check("t3_no_last", last_seen - l0, 0);
    check("t3_pops", pop_cnt - p0, 2);
    check("t3_sb_empty", sb.size(), 0);

    // Abort mid-frame, cycle after the second pop; also start clears underrun.
    for (int i = 0; i < 4; i++) push(16'h0031 + 16'(i));
    expect_s(16'h0031, 1'b1, 1'b0);
    pulse_start;
    @(negedge rd_clk);
    check("t4_underrun_cleared", {31'd0, underrun}, 32'd0);
    n = rd_en ? 1 : 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge rd_clk);
      if (rd_en) n++;
    end
    check("t4_two_pops", n, 2);
    tick;
    abort   = 1'b1;
    m_ready = 1'b0;
    @(negedge rd_clk);
    check("t4_no_pop_on_abort", {31'd0, rd_en}, 32'd0);
    tick;
    abort   = 1'b0;
    m_ready = 1'b1;
    @(negedge rd_clk);
    check("t4_valid_dropped", {31'd0, m_valid}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_fifo_level", {26'd0, tail - head}, 32'd2);
    check("t4_fifo_head", {16'd0, rd_data}, 32'h0033);
    tick;
    flush_fifo;
    check("t4_sb_empty", sb.size(), 0);

    // Second start during FETCH is ignored.
    p0 = pop_cnt;
    f0 = fd_cnt;
    load_frame(16'h0041, FL);
    pulse_start;
    tick;
    pulse_start;
    wait_idle("t5_idle_timeout");
    tick;
    check("t5_pops", pop_cnt - p0, 4);
    check("t5_done_count", fd_cnt - f0, 1);
    check("t5_sb_empty", sb.size(), 0);
    repeat (3) tick;
    check("t5_no_restart", {31'd0, busy}, 32'd0);

    // Reset mid-frame with a sample held in the output register.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0051 + 16'(i));
    pulse_start;
    tick;
    tick;
    @(negedge rd_clk);
    check("t6_held_before_reset", {31'd0, m_valid}, 32'd1);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    check_reset_outputs("t6_midframe");
    tick;
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    flush_fifo;
    tick;

    // Three good frames, then one underrun frame.
    f0 = fd_cnt;
    for (int j = 0; j < 3; j++) begin
      load_frame(16'h0100 + 16'(j * 16), FL);
      pulse_start;
      wait_idle("t7_good_idle_timeout");
    end
    push(16'h0200);
    expect_s(16'h0200, 1'b1, 1'b0);
    pulse_start;
    wait_idle("t7_under_idle_timeout");
    tick;
    check("t7_done_count", fd_cnt - f0, 3);
    check("t7_underrun_flag", {31'd0, underrun}, 32'd1);
    check("t7_sb_empty", sb.size(), 0);
`ifdef LMS_FRAME_READER_STATS_EN
    check("t7_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    check("t7_underrun_cnt", {16'd0, underrun_cnt}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lms_fifo_frame_reader.md
Name: lms_fifo_frame_reader

Overview:
- Read-side consumer of the LMS sample prefetch FIFO.
- On a start pulse, pops exactly FRAME_LEN samples through the FIFO's rd_en/rd_vld/rd_data prefetch interface.
- Presents them to the LMS filter core on a registered valid/ready stream tagged with first/last markers.
- Detects FIFO starvation (underrun timeout) and supports a synchronous abort.

Parameters:
- DATA_WIDTH, 16, sample width; equals FIFO read data width.
- FRAME_LEN, 256, samples per frame; legal range 2..65535.
- TIMEOUT, 1024, consecutive rd_vld-low cycles in FETCH that declare underrun; legal range 1..65535.

Ports:
- rd_clk  in  1  single clock for the whole block
- rd_rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
- abort  in  1  synchronous frame cancel
- rd_vld  in  1  FIFO head holds valid data (prefetch; data visible before pop)
- rd_data  in  DATA_WIDTH  FIFO head sample
- rd_en  out  1  pop strobe to FIFO
- m_valid  out  1  output sample valid
- m_ready  in  1  LMS core accepts sample
- m_data  out  DATA_WIDTH  output sample
- m_first  out  1  qualifies m_data as sample 0 of the frame
- m_last  out  1  qualifies m_data as sample FRAME_LEN-1
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a complete frame has been handed off
- underrun  out  1  sticky underrun flag; cleared by rd_rst or by the next accepted start

Behaviour:
- Interface: single clock, rd_clk; synchronous active-high reset, rd_rst.
- Reset values: rd_en=0, m_valid=0, m_data=0, m_first=0, m_last=0, busy=0, frame_done=0, underrun=0; state=IDLE; counters=0.
- Output stage is one register, m_*.
  - load = rd_en; rd_en = (state==FETCH) && rd_vld && (!m_valid || m_ready) && (cnt < FRAME_LEN). Combinational from registered state, inputs and registers.
  - On load: m_data<=rd_data, m_valid<=1, m_first<=(cnt==0), m_last<=(cnt==FRAME_LEN-1), cnt<=cnt+1.
  - On m_valid && m_ready without load: m_valid<=0.
  - m_data/m_first/m_last hold while m_valid && !m_ready.
- Throughput is 1 sample/cycle with m_ready held high. Latency is 1 cycle from pop to m_valid.
- FSM:
  - IDLE: start -> FETCH; cnt<=0, idle_cnt<=0, underrun<=0.
  - FETCH: pops as above. After the pop with cnt==FRAME_LEN-1 -> DRAIN.
    - idle_cnt increments each cycle rd_vld==0; it resets on rd_vld==1.
    - When idle_cnt reaches TIMEOUT-1 with rd_vld still 0: underrun<=1 -> DRAIN (partial frame; m_last is never asserted).
  - DRAIN: wait until m_valid==0 or (m_valid && m_ready). Then -> IDLE, and frame_done pulses only if cnt==FRAME_LEN and no underrun occurred.
- abort (any non-IDLE state, highest priority):
  - -> IDLE next cycle; m_valid<=0; rd_en=0 in the abort cycle; no frame_done.
  - The FIFO is never popped on the abort cycle.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- rd_rst mid-frame: all state to reset values next edge; a sample held in m_data is discarded.
- Counter widths are clog2(FRAME_LEN+1) and clog2(TIMEOUT+1), with no wrap within a frame.

Optional Feature:
- Macro: LMS_FRAME_READER_STATS_EN.
- With the macro defined, two extra outputs are added:
  - frame_cnt [15:0]: increments on each frame_done.
  - underrun_cnt [15:0]: increments on each underrun set event.
  - Both saturate at 16'hFFFF and reset to 0 on rd_rst.
- Without the macro, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package lms_reader_pkg holds:
  - FSM state enum: IDLE, FETCH, DRAIN.
  - Default constants: LMS_SAMPLE_W=16, LMS_FRAME_LEN=256, LMS_UNDERRUN_TIMEOUT=1024.
- One natural sub-module: lms_out_reg_stage, the single-entry registered valid/ready output stage with first/last sideband. The FSM and counters stay in the top.

Test Plan:
- FRAME_LEN=4 for the short scenarios below.
- Full frame, continuous: FIFO preloaded with 0x0001..0x0004, m_ready=1, start pulse.
  - m_valid for 4 consecutive cycles starting 1 cycle after the first rd_en, data 1,2,3,4.
  - m_first on 1 only, m_last on 4 only; frame_done 1 cycle after last accept; busy falls the same cycle.
- Backpressure: m_ready toggled 1,0,0,1,...
  - Data is held stable while stalled; rd_en=0 whenever m_valid && !m_ready; exactly 4 pops total, with no duplicates or drops.
- Underrun: TIMEOUT=8, only 2 samples available.
  - 2 samples are output; after 8 rd_vld-low cycles, underrun=1 and return to IDLE with no frame_done and m_last never set.
  - The next start clears underrun.
- Abort mid-frame: abort on the cycle after sample 2 is popped.
  - m_valid=0 next cycle, rd_en=0 in the abort cycle, state IDLE; FIFO still holds samples 3,4.
- Start while busy plus reset mid-frame:
  - A second start during FETCH is ignored (still exactly 4 samples).
  - rd_rst asserted mid-frame sets all outputs to reset values on the next edge.
- With LMS_FRAME_READER_STATS_EN defined: 3 good frames then 1 underrun frame -> frame_cnt=3, underrun_cnt=1.
